// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a WIDTH-bit pattern out MSB first, repeated rep_in times.
// Optional even-parity bit after each repetition when PARITY_PIPE_EN is defined.
module seq_pattern_tx #(
  parameter int   WIDTH      = 4,
  parameter int   CNT_W      = 8,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pat_in,
  input  logic [CNT_W-1:0] rep_in,
  input  logic             start,
  input  logic             abort,
  output logic             ready,
  output logic             serial_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

`ifdef PARITY_PIPE_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PAR} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT} state_t;
`endif

  state_t           state_reg;
  logic [WIDTH-1:0] pat_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [CNT_W-1:0] reps_reg;
  logic             serial_reg;
  logic             valid_reg;
  logic             busy_reg;
  logic             done_reg;

  logic             last_bit;
  logic             last_rep;
  logic [CNT_W-1:0] rep_eff;

  assign last_bit = (idx_reg == '0);
  assign last_rep = (reps_reg <= CNT_W'(1));
  // A zero repeat count still sends the pattern once.
  assign rep_eff  = (rep_in == '0) ? CNT_W'(1) : rep_in;

`ifdef PARITY_PIPE_EN
  logic parity_bit;
  assign parity_bit = ^pat_reg;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      pat_reg    <= '0;
      idx_reg    <= '0;
      reps_reg   <= '0;
      serial_reg <= IDLE_LEVEL;
      valid_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start && !abort) begin
            pat_reg    <= pat_in;
            reps_reg   <= rep_eff;
            idx_reg    <= IDX_MSB;
            serial_reg <= pat_in[WIDTH-1];
            valid_reg  <= 1'b1;
            busy_reg   <= 1'b1;
            state_reg  <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (abort) begin
            state_reg  <= ST_IDLE;
            serial_reg <= IDLE_LEVEL;
            valid_reg  <= 1'b0;
            busy_reg   <= 1'b0;
          end else if (!last_bit) begin
            idx_reg    <= idx_reg - 1'b1;
            serial_reg <= pat_reg[idx_reg - 1'b1];
          end else begin
`ifdef PARITY_PIPE_EN
            state_reg  <= ST_PAR;
            serial_reg <= parity_bit;
`else
            if (!last_rep) begin
              // Wrap straight to the MSB so repetitions run without gap bits.
              reps_reg   <= reps_reg - 1'b1;
              idx_reg    <= IDX_MSB;
              serial_reg <= pat_reg[WIDTH-1];
            end else begin
              state_reg  <= ST_IDLE;
              serial_reg <= IDLE_LEVEL;
              valid_reg  <= 1'b0;
              busy_reg   <= 1'b0;
              done_reg   <= 1'b1;
            end
`endif
          end
        end

`ifdef PARITY_PIPE_EN
        ST_PAR: begin
          if (abort) begin
            state_reg  <= ST_IDLE;
            serial_reg <= IDLE_LEVEL;
            valid_reg  <= 1'b0;
            busy_reg   <= 1'b0;
          end else if (!last_rep) begin
            reps_reg   <= reps_reg - 1'b1;
            idx_reg    <= IDX_MSB;
            serial_reg <= pat_reg[WIDTH-1];
            state_reg  <= ST_SHIFT;
          end else begin
            state_reg  <= ST_IDLE;
            serial_reg <= IDLE_LEVEL;
            valid_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b1;
          end
        end
`endif

        default: begin
          state_reg  <= ST_IDLE;
          serial_reg <= IDLE_LEVEL;
          valid_reg  <= 1'b0;
          busy_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign ready      = (state_reg == ST_IDLE);
  assign serial_out = serial_reg;
  assign bit_valid  = valid_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: vector table, randomized frames against a queue-based frame model,
// and hand-written sequences for reset, abort, back-to-back and (with PARITY_PIPE_EN) parity.
module tb_seq_pattern_tx;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;
`ifdef PARITY_PIPE_EN
  localparam int BPR = WIDTH + 1;
`else
  localparam int BPR = WIDTH;
`endif

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] pat_in;
  logic [CNT_W-1:0] rep_in;
  logic             start;
  logic             abort;
  logic             ready;
  logic             serial_out;
  logic             bit_valid;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  typedef struct {
    logic [WIDTH-1:0] pat;
    logic [CNT_W-1:0] rep;
    int               abort_at;
    int               exp_valid;
    bit               exp_done;
  } vec_t;

  vec_t vecs[10];

  seq_pattern_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W), .IDLE_LEVEL(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .pat_in     (pat_in),
    .rep_in     (rep_in),
    .start      (start),
    .abort      (abort),
    .ready      (ready),
    .serial_out (serial_out),
    .bit_valid  (bit_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame: every repetition is the pattern MSB first, plus its even parity if enabled.
  task automatic build_frame(input logic [WIDTH-1:0] pat, input logic [CNT_W-1:0] rep);
    int reps;
    exp_q.delete();
    reps = (rep == 0) ? 1 : int'(rep);
    for (int r = 0; r < reps; r++) begin
      for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(pat[i]);
`ifdef PARITY_PIPE_EN
      exp_q.push_back(^pat);
`endif
    end
  endtask

  task automatic check_idle(input string tag, input logic exp_done);
    check({tag, "_valid"}, bit_valid, 0);
    check({tag, "_serial"}, serial_out, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ready"}, ready, 1);
    check({tag, "_done"}, done, exp_done);
  endtask

  task automatic run_frame(input logic [WIDTH-1:0] pat, input logic [CNT_W-1:0] rep,
                           input int abort_at, input int exp_valid, input bit exp_done);
    int n;
    int valid_cnt;
    bit aborted;
    bit saw_done;
    valid_cnt = 0;
    aborted = 0;
    @(negedge clk);
    pat_in = pat; rep_in = rep; start = 1'b1; abort = 1'b0;
    @(negedge clk);
    start = 1'b0;
    pat_in = WIDTH'($urandom);
    rep_in = CNT_W'($urandom);
    build_frame(pat, rep);
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      check("frame_valid", bit_valid, 1);
      check("frame_bit", serial_out, exp_q[k]);
      check("frame_busy", busy, 1);
      check("frame_ready", ready, 0);
      check("frame_done", done, 0);
      valid_cnt += int'(bit_valid);
      if (k == abort_at) begin
        abort = 1'b1;
        aborted = 1;
        break;
      end
      pat_in = WIDTH'($urandom);
      start = (k < n - 1) ? 1'($urandom) : 1'b0;
    end
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check_idle("end", !aborted);
    saw_done = done;
    @(negedge clk);
    check_idle("post", 0);
    check("valid_cycles", valid_cnt, exp_valid);
    check("done_seen", saw_done, exp_done);
    $display("frame pat=%b rep=%0d abort_at=%0d valid_cycles=%0d done=%0d",
             pat, rep, abort_at, valid_cnt, saw_done);
  endtask

  initial begin
    int reps;
    int ab;
    logic [WIDTH-1:0] rp;
    logic [9:0] t6;

    reset = 1'b1; pat_in = '0; rep_in = '0; start = 1'b0; abort = 1'b0;
    @(negedge clk); @(negedge clk);
    check_idle("reset", 0);
    reset = 1'b0;
    @(negedge clk);
    check_idle("after_reset", 0);

    vecs[0] = '{4'b0110, 8'd1,   -1,      BPR,       1'b1};
    vecs[1] = '{4'b0110, 8'd3,   -1,      3 * BPR,   1'b1};
    vecs[2] = '{4'b0110, 8'd0,   -1,      BPR,       1'b1};
    vecs[3] = '{4'b1001, 8'd2,   -1,      2 * BPR,   1'b1};
    vecs[4] = '{4'b1111, 8'd4,   -1,      4 * BPR,   1'b1};
    vecs[5] = '{4'b0000, 8'd1,   -1,      BPR,       1'b1};
    vecs[6] = '{4'b0110, 8'd3,   BPR + 1, BPR + 2,   1'b0};
    vecs[7] = '{4'b1010, 8'd2,   0,       1,         1'b0};
    vecs[8] = '{4'b0011, 8'd1,   BPR - 1, BPR,       1'b0};
    vecs[9] = '{4'b1100, 8'd255, -1,      255 * BPR, 1'b1};

    for (int v = 0; v < 10; v++)
      run_frame(vecs[v].pat, vecs[v].rep, vecs[v].abort_at, vecs[v].exp_valid, vecs[v].exp_done);

    // abort together with start in IDLE must not accept a frame
    @(negedge clk);
    pat_in = 4'b1111; rep_in = 8'd2; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    check_idle("abort_start", 0);
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check_idle("abort_start2", 0);
    $display("abort+start in idle: ready=%0d bit_valid=%0d", ready, bit_valid);

    // start held high: one frame, done cycle, then the next frame begins immediately
    rp = 4'b1011;
    build_frame(rp, 8'd1);
    @(negedge clk);
    pat_in = rp; rep_in = 8'd1; start = 1'b1;
    for (int c = 0; c <= 2 * BPR + 1; c++) begin
      @(negedge clk);
      if (c == BPR || c == 2 * BPR + 1) begin
        check_idle("b2b_gap", 1);
      end else begin
        check("b2b_valid", bit_valid, 1);
        check("b2b_bit", serial_out, exp_q[(c < BPR) ? c : c - BPR - 1]);
        check("b2b_done", done, 0);
      end
      if (c == BPR + 1) start = 1'b0;
    end
    @(negedge clk);
    check_idle("b2b_end", 0);
    $display("back-to-back frames pat=%b complete", rp);

    // asynchronous reset in the middle of a frame
    @(negedge clk);
    pat_in = 4'b0110; rep_in = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_reset_valid", bit_valid, 1);
    #2 reset = 1'b1;
    #1 check_idle("async_reset", 0);
    @(negedge clk);
    reset = 1'b0;
    $display("async reset mid-frame: bit_valid=%0d busy=%0d", bit_valid, busy);
    run_frame(4'b0110, 8'd1, -1, BPR, 1'b1);

`ifdef PARITY_PIPE_EN
    t6 = 10'b0111101111;
    @(negedge clk);
    pat_in = 4'b0111; rep_in = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      check("par_valid", bit_valid, 1);
      check("par_bit", serial_out, t6[9 - c]);
    end
    @(negedge clk);
    check_idle("par_end", 1);
    $display("parity frame pat=0111 rep=2 complete");
`else
    t6 = '0;
`endif

    for (int i = 0; i < 40; i++) begin
      rp = WIDTH'($urandom);
      rep_in = CNT_W'($urandom_range(0, 4));
      reps = (rep_in == 0) ? 1 : int'(rep_in);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, reps * BPR - 1)) : -1;
      run_frame(rp, rep_in, ab, (ab < 0) ? reps * BPR : ab + 1, ab < 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
